// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key tracker: prefix bytes, frame FSM encoding
// and the default game-control key map.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         KEY_ENTRY_W    = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Entry 0 is the least significant: up, down, left, right (extended), space,
  // w, a, s, d, tab, enter, backspace.
  localparam logic [12*KEY_ENTRY_W-1:0] PS2_DEFAULT_KEYMAP = {
    9'h066, 9'h05A, 9'h00D, 9'h023, 9'h01B, 9'h01C,
    9'h01D, 9'h029, 9'h174, 9'h16B, 9'h172, 9'h175
  };

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus run-length filter for one raw PS/2 line; idles high.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  // The output flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (sync[SYNC_STAGES-1] != dout) begin
      if (cnt == CNT_MAX) begin
        dout <= sync[SYNC_STAGES-1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: deframes scan codes, decodes E0/F0 prefixes and
// keeps a held/released bitmap for a parametrised key table.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int NUM_KEYS       = 12,
  parameter logic [NUM_KEYS*KEY_ENTRY_W-1:0] KEYMAP = PS2_DEFAULT_KEYMAP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kclk,
  input  logic                kdata,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                code_valid,
  output logic [7:0]          code,
  output logic                code_ext,
  output logic                code_brk,
  output logic                parity_err,
  output logic                frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic kclk_f, kdata_f, kclk_p1, strobe;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_kclk_filt (
    .clk(clk), .rst_n(rst_n), .din(kclk), .dout(kclk_f)
  );
  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_kdata_filt (
    .clk(clk), .rst_n(rst_n), .din(kdata), .dout(kdata_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kclk_p1 <= 1'b1;
    else        kclk_p1 <= kclk_f;
  end

  assign strobe = kclk_p1 & ~kclk_f;

  ps2_state_t          state, state_d;
  logic [2:0]          bitcnt;
  logic [7:0]          shreg;
  logic                par_bit;
  logic [WD_W-1:0]     wdog;
  logic                ext_flag, brk_flag;
  logic                shift_en, cap_par, start_en;
  logic                end_ok, end_perr, end_ferr, timeout;
  logic [NUM_KEYS-1:0] key_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // A strobe always takes priority over watchdog expiry.
  always_comb begin
    state_d  = state;
    start_en = 1'b0;
    shift_en = 1'b0;
    cap_par  = 1'b0;
    end_ok   = 1'b0;
    end_perr = 1'b0;
    end_ferr = 1'b0;
    timeout  = 1'b0;
    if (strobe) begin
      case (state)
        IDLE: if (!kdata_f) begin
          state_d  = DATA;
          start_en = 1'b1;
        end
        DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          cap_par = 1'b1;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!kdata_f)                 end_ferr = 1'b1;
          else if (!(^{shreg, par_bit})) end_perr = 1'b1;
          else                          end_ok   = 1'b1;
        end
      endcase
    end else if (state != IDLE && wdog == WD_LAST) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      wdog   <= '0;
    end else begin
      if (start_en)      bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 1'b1;
      if (strobe || timeout || state == IDLE) wdog <= '0;
      else                                    wdog <= wdog + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg   <= {kdata_f, shreg[7:1]};
    if (cap_par)  par_bit <= kdata_f;
  end

  always_comb begin
    key_next = key_state;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEYMAP[KEY_ENTRY_W*i +: KEY_ENTRY_W] == {ext_flag, shreg})
        key_next[i] = ~brk_flag;
    end
  end

  // Output stage: registered one clk after the stop-bit strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state  <= '0;
      code_valid <= 1'b0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_brk   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= end_perr;
      frame_err  <= end_ferr | timeout;
      if (end_perr || end_ferr || timeout) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (end_ok) begin
        if (shreg == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          code       <= shreg;
          code_ext   <= ext_flag;
          code_brk   <= brk_flag;
          code_valid <= 1'b1;
          key_state  <= key_next;
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: bit-banged PS/2 frames with
// hand-computed key bitmaps and pulse counts.
module tb_ps2_key_tracker;

  localparam int NK = 12;
  localparam logic [NK*9-1:0] MAP = {
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
    9'h029, 9'h023, 9'h01C, 9'h075, 9'h175, 9'h01D
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          kclk = 1'b1;
  logic          kdata = 1'b1;
  logic [NK-1:0] key_state;
  logic          code_valid, code_ext, code_brk, parity_err, frame_err;
  logic [7:0]    code;

  int n_cmp = 0;
  int n_bad = 0;
  int cv_cnt = 0, pe_cnt = 0, fe_cnt = 0;
  logic [NK-1:0] key_at_cv = '0;
  int cv0, pe0, fe0;

  ps2_key_tracker #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(25000),
    .NUM_KEYS(NK), .KEYMAP(MAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata),
    .key_state(key_state), .code_valid(code_valid), .code(code),
    .code_ext(code_ext), .code_brk(code_brk),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid) begin
        cv_cnt++;
        key_at_cv = key_state;
      end
      if (parity_err) pe_cnt++;
      if (frame_err)  fe_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    kdata = v;
    idle(10);
    kclk = 1'b0;
    idle(20);
    kclk = 1'b1;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop_bit);
    kdata = 1'b1;
    idle(30);
  endtask

  task automatic snap();
    cv0 = cv_cnt;
    pe0 = pe_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    idle(5);
    chk("rst_key_state", key_state, 0);
    chk("rst_pulses", {code_valid, parity_err, frame_err}, 0);
    chk("rst_code", {code_ext, code_brk, code}, 0);
    rst_n = 1'b1;
    idle(20);

    // make then break
    snap();
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("make_cv", cv_cnt - cv0, 1);
    chk("make_code", {code_ext, code_brk, code}, 10'h01D);
    chk("make_key", key_state, 12'h001);
    chk("make_key_at_cv", key_at_cv, 12'h001);
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("break_cv", cv_cnt - cv0, 1);
    chk("break_code", {code_ext, code_brk, code}, 10'h11D);
    chk("break_key", key_state, 12'h000);

    // extended vs plain
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("ext_make_code", {code_ext, code_brk, code}, 10'h275);
    chk("ext_make_key", key_state, 12'h002);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("plain_make_key", key_state, 12'h006);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("ext_brk_code", {code_ext, code_brk, code}, 10'h375);
    chk("ext_brk_key", key_state, 12'h004);

    // parity error after a prefix: prefix must be dropped
    send_frame(8'hE0, 1'b0, 1'b1);
    snap();
    send_frame(8'h1D, 1'b1, 1'b1);
    chk("perr_pulse", pe_cnt - pe0, 1);
    chk("perr_no_cv", cv_cnt - cv0, 0);
    chk("perr_key", key_state, 12'h004);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("after_perr_code", {code_ext, code_brk, code}, 10'h01D);
    chk("after_perr_key", key_state, 12'h005);

    // bad stop bit
    snap();
    send_frame(8'h29, 1'b0, 1'b0);
    idle(30);
    chk("stop_ferr", fe_cnt - fe0, 1);
    chk("stop_no_cv", cv_cnt - cv0, 0);

    // timeout on a partial frame
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    kdata = 1'b1;
    idle(25100);
    chk("timeout_ferr", fe_cnt - fe0, 1);
    chk("timeout_no_cv", cv_cnt - cv0, 0);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("after_to_cv", cv_cnt - cv0, 1);
    chk("after_to_code", {code_ext, code_brk, code}, 10'h029);
    chk("after_to_key", key_state, 12'h025);

    // short kclk glitch with data low must not start a frame
    snap();
    kdata = 1'b0;
    idle(5);
    kclk = 1'b0;
    idle(7);
    kclk = 1'b1;
    idle(5);
    kdata = 1'b1;
    idle(30);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("glitch_errs", (pe_cnt - pe0) + (fe_cnt - fe0), 0);
    chk("glitch_code", {code_ext, code_brk, code}, 10'h01C);
    chk("glitch_key", key_state, 12'h02D);

    // multi-key hold, then release one
    send_frame(8'h23, 1'b0, 1'b1);
    chk("multi_key", key_state, 12'h03D);
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("typematic_key", key_state, 12'h03D);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("multi_brk_key", key_state, 12'h035);

    // reset mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    idle(3);
    chk("midrst_key", key_state, 0);
    chk("midrst_out", {code_valid, parity_err, frame_err, code_ext, code_brk, code}, 0);
    kdata = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(20);
    snap();
    send_frame(8'h1D, 1'b0, 1'b1);
    chk("postrst_cv", cv_cnt - cv0, 1);
    chk("postrst_code", {code_ext, code_brk, code}, 10'h01D);
    chk("postrst_key", key_state, 12'h001);
    chk("postrst_errs", (pe_cnt - pe0) + (fe_cnt - fe0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
